// File: rtl/arm_run_pkg.sv
// rtl/arm_run_pkg.sv - shared state encoding and defaults for the ARM run sequencer
package arm_run_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RESET  = 3'd1,
        ST_RUN    = 3'd2,
        ST_REPORT = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int CFG_FWD_BIT         = 0;
    localparam int DEF_RST_HOLD_CYCLES = 2;
    localparam int DEF_RUN_CYCLES      = 1000;

endpackage

// File: rtl/arm_cfg_picker.sv
// rtl/arm_cfg_picker.sv - combinational finder of the next set mask bit above the current index
module arm_cfg_picker #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] mask,
    input  logic [W-1:0] cur,
    input  logic         from_none,
    output logic [W-1:0] nxt,
    output logic         has_next
);

    // Descending scan so the lowest qualifying index is the last to win.
    always_comb begin
        nxt      = '0;
        has_next = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i] && (from_none || (W'(i) > cur))) begin
                nxt      = W'(i);
                has_next = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arm_run_sequencer.sv
// rtl/arm_run_sequencer.sv - sweeps core configurations, one bounded reset+run per config
module arm_run_sequencer
    import arm_run_pkg::*;
#(
    parameter int RST_HOLD_CYCLES = DEF_RST_HOLD_CYCLES,
    parameter int RUN_CYCLES      = DEF_RUN_CYCLES,
    parameter int NUM_CONFIGS     = 2,
    parameter int CNT_W           = 16,
    parameter int CFG_W           = (NUM_CONFIGS > 2) ? $clog2(NUM_CONFIGS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [NUM_CONFIGS-1:0] cfg_mask,
    input  logic                   cpu_halt,
    output logic                   cpu_rst,
    output logic                   enable_forwarding,
    output logic [CFG_W-1:0]       cur_cfg,
    output logic                   busy,
    output logic                   result_valid,
    output logic [CFG_W-1:0]       result_cfg,
    output logic [CNT_W-1:0]       result_cycles,
    output logic                   result_halted,
    output logic                   done
);

    localparam int HOLD_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;

    state_t                 state_q, state_d;
    logic [HOLD_W-1:0]      hold_q;
    logic [CNT_W-1:0]       cyc_q;
    logic [CFG_W-1:0]       cfg_q;
    logic [NUM_CONFIGS-1:0] mask_q;
    logic [CFG_W-1:0]       res_cfg_q;
    logic [CNT_W-1:0]       res_cyc_q;
    logic                   res_halt_q;

    logic                   in_idle;
    logic [NUM_CONFIGS-1:0] pick_mask;
    logic [CFG_W-1:0]       pick_nxt;
    logic                   pick_has;
    logic                   run_last;

    // In IDLE the mask is not latched yet, so the first pick looks at the live port.
    assign in_idle   = (state_q == ST_IDLE);
    assign pick_mask = in_idle ? cfg_mask : mask_q;
    assign run_last  = (cyc_q == CNT_W'(RUN_CYCLES - 1));

    arm_cfg_picker #(
        .N (NUM_CONFIGS),
        .W (CFG_W)
    ) u_picker (
        .mask      (pick_mask),
        .cur       (cfg_q),
        .from_none (in_idle),
        .nxt       (pick_nxt),
        .has_next  (pick_has)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = pick_has ? ST_RESET : ST_DONE;
            ST_RESET:  if (hold_q == HOLD_W'(RST_HOLD_CYCLES - 1)) state_d = ST_RUN;
            ST_RUN:    if (cpu_halt || run_last) state_d = ST_REPORT;
            ST_REPORT: state_d = pick_has ? ST_RESET : ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (abort && !in_idle) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q     <= '0;
            cyc_q      <= '0;
            cfg_q      <= '0;
            mask_q     <= '0;
            res_cfg_q  <= '0;
            res_cyc_q  <= '0;
            res_halt_q <= 1'b0;
        end else begin
            hold_q <= (state_q == ST_RESET) ? hold_q + 1'b1 : '0;
            cyc_q  <= (state_q == ST_RUN)   ? cyc_q + 1'b1  : '0;
            if (in_idle && start) mask_q <= cfg_mask;
            // Config only moves on entry to RESET, so forwarding never toggles while the core runs.
            if (state_d == ST_RESET && state_q != ST_RESET) cfg_q <= pick_nxt;
            if (state_q == ST_RUN && state_d == ST_REPORT) begin
                res_cfg_q  <= cfg_q;
                res_cyc_q  <= cyc_q + 1'b1;
                res_halt_q <= cpu_halt;
            end
        end
    end

    assign cpu_rst           = (state_q != ST_RUN);
    assign busy              = !in_idle;
    assign result_valid      = (state_q == ST_REPORT);
    assign done              = (state_q == ST_DONE);
    assign cur_cfg           = cfg_q;
    assign enable_forwarding = cfg_q[CFG_FWD_BIT];
    assign result_cfg        = res_cfg_q;
    assign result_cycles     = res_cyc_q;
    assign result_halted     = res_halt_q;

endmodule

// File: tb/tb_arm_run_sequencer.sv
// tb/tb_arm_run_sequencer.sv - self-checking bench for arm_run_sequencer
module tb_arm_run_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, abort, cpu_halt;
    logic [3:0] cfg_mask;
    logic       cpu_rst, enable_forwarding, busy, result_valid, result_halted, done;
    logic [1:0] cur_cfg, result_cfg;
    logic [7:0] result_cycles;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    arm_run_sequencer #(
        .RST_HOLD_CYCLES (2),
        .RUN_CYCLES      (8),
        .NUM_CONFIGS     (4),
        .CNT_W           (8)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .abort             (abort),
        .cfg_mask          (cfg_mask),
        .cpu_halt          (cpu_halt),
        .cpu_rst           (cpu_rst),
        .enable_forwarding (enable_forwarding),
        .cur_cfg           (cur_cfg),
        .busy              (busy),
        .result_valid      (result_valid),
        .result_cfg        (result_cfg),
        .result_cycles     (result_cycles),
        .result_halted     (result_halted),
        .done              (done)
    );

    typedef struct packed {
        logic       cr;
        logic       b;
        logic       ef;
        logic [1:0] cc;
        logic       rv;
        logic [1:0] rc;
        logic [7:0] ry;
        logic       rh;
        logic       d;
    } outs_t;

    typedef struct {
        logic       s;
        logic       a;
        logic       h;
        logic [3:0] m;
        outs_t      e;
    } vec_t;

    vec_t tbl[16];
    int   q_cfg[$], q_cyc[$], q_halt[$], q_ef[$];
    int   ef_bad;

    function automatic vec_t v(logic s, logic a, logic h, logic [3:0] m,
                               logic cr, logic b, logic ef, logic [1:0] cc, logic rv,
                               logic [1:0] rc, logic [7:0] ry, logic rh, logic d);
        vec_t r;
        r.s = s; r.a = a; r.h = h; r.m = m;
        r.e = '{cr: cr, b: b, ef: ef, cc: cc, rv: rv, rc: rc, ry: ry, rh: rh, d: d};
        return r;
    endfunction

    function automatic outs_t sample();
        return '{cr: cpu_rst, b: busy, ef: enable_forwarding, cc: cur_cfg, rv: result_valid,
                 rc: result_cfg, ry: result_cycles, rh: result_halted, d: done};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic sweep(input logic [3:0] m, input int halt_at, output bit got_done);
        int   runc;
        logic prev_rst, prev_ef;
        q_cfg.delete(); q_cyc.delete(); q_halt.delete(); q_ef.delete();
        runc = 0; got_done = 0; ef_bad = 0; prev_rst = 1'b1; prev_ef = 1'b0;
        start = 1'b1; cfg_mask = m;
        step();
        start = 1'b0; cfg_mask = ~m;
        for (int c = 0; c < 200; c++) begin
            cpu_halt = 1'b0;
            if (!cpu_rst) begin
                runc++;
                if (runc == halt_at) cpu_halt = 1'b1;
                if (!prev_rst && enable_forwarding !== prev_ef) ef_bad++;
                if (enable_forwarding !== cur_cfg[0]) ef_bad++;
            end
            if (result_valid) begin
                q_cfg.push_back(int'(result_cfg));
                q_cyc.push_back(int'(result_cycles));
                q_halt.push_back(int'(result_halted));
                q_ef.push_back(int'(enable_forwarding));
                runc = 0;
            end
            prev_rst = cpu_rst; prev_ef = enable_forwarding;
            if (done) begin
                got_done = 1;
                break;
            end
            step();
        end
        cpu_halt = 1'b0;
        if (got_done) step();
    endtask

    task automatic exp_run(input string tag, input int idx, input int cfg, input int cyc, input int halt);
        if (idx < q_cfg.size()) begin
            chk({tag, "_cfg"}, q_cfg[idx], cfg);
            chk({tag, "_cycles"}, q_cyc[idx], cyc);
            chk({tag, "_halted"}, q_halt[idx], halt);
            chk({tag, "_fwd"}, q_ef[idx], cfg & 1);
        end else begin
            chk({tag, "_missing"}, q_cfg.size(), idx + 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        int runc;
        logic seen;

        // Single config 0001, empty mask, ignored abort/start/halt in non-applicable states.
        tbl[0]  = v(1, 0, 0, 4'b0001, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = v(0, 0, 1, 4'b0001, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 2; i <= 9; i++) tbl[i] = v(0, 0, 0, 4'b0001, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[4]  = v(1, 0, 0, 4'b1000, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        tbl[10] = v(0, 0, 0, 4'b0000, 1, 1, 0, 0, 1, 0, 8, 0, 0);
        tbl[11] = v(1, 0, 0, 4'b0000, 1, 1, 0, 0, 0, 0, 8, 0, 1);
        tbl[12] = v(0, 0, 0, 4'b0000, 1, 0, 0, 0, 0, 0, 8, 0, 0);
        tbl[13] = v(1, 0, 0, 4'b0000, 1, 1, 0, 0, 0, 0, 8, 0, 1);
        tbl[14] = v(0, 0, 0, 4'b0000, 1, 0, 0, 0, 0, 0, 8, 0, 0);
        tbl[15] = v(0, 1, 0, 4'b0000, 1, 0, 0, 0, 0, 0, 8, 0, 0);

        rst = 1'b0; start = 1'b0; abort = 1'b0; cpu_halt = 1'b0; cfg_mask = 4'b0;
        step();
        step();
        chk("reset_state", 32'(sample()), 32'(outs_t'({1'b1, 17'b0})));
        rst = 1'b1;

        for (int i = 0; i < 16; i++) begin
            start = tbl[i].s; abort = tbl[i].a; cpu_halt = tbl[i].h; cfg_mask = tbl[i].m;
            step();
            chk($sformatf("vec%0d", i), 32'(sample()), 32'(tbl[i].e));
        end
        start = 1'b0; abort = 1'b0; cpu_halt = 1'b0;

        sweep(4'b1010, 0, got);
        chk("sweep_done", 32'(got), 1);
        chk("sweep_nres", q_cfg.size(), 2);
        exp_run("sweep0", 0, 1, 8, 0);
        exp_run("sweep1", 1, 3, 8, 0);
        chk("sweep_fwd_stable", ef_bad, 0);

        sweep(4'b0001, 3, got);
        chk("halt3_nres", q_cfg.size(), 1);
        exp_run("halt3", 0, 0, 3, 1);

        sweep(4'b0001, 8, got);
        chk("halt8_nres", q_cfg.size(), 1);
        exp_run("halt8", 0, 0, 8, 1);

        // Abort during the 4th RUN cycle of cfg 0.
        start = 1'b1; cfg_mask = 4'b0011;
        step();
        start = 1'b0;
        runc = 0;
        for (int c = 0; c < 40; c++) begin
            if (!cpu_rst) runc++;
            if (runc == 4) break;
            step();
        end
        chk("abort_reach_run4", runc, 4);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_cpu_rst", 32'(cpu_rst), 1);
        seen = result_valid | done;
        for (int c = 0; c < 3; c++) begin
            step();
            seen = seen | result_valid | done | busy;
        end
        chk("abort_quiet", 32'(seen), 0);
        sweep(4'b0011, 0, got);
        chk("after_abort_nres", q_cfg.size(), 2);
        exp_run("after_abort0", 0, 0, 8, 0);
        exp_run("after_abort1", 1, 1, 8, 0);

        // Asynchronous reset between edges while running cfg 1.
        start = 1'b1; cfg_mask = 4'b0010;
        step();
        start = 1'b0;
        runc = 0;
        for (int c = 0; c < 40; c++) begin
            if (!cpu_rst) runc++;
            if (runc == 3) break;
            step();
        end
        chk("arst_reach_run", runc, 3);
        #2 rst = 1'b0;
        #1;
        chk("arst_cpu_rst", 32'(cpu_rst), 1);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_fwd", 32'(enable_forwarding), 0);
        chk("arst_result_cycles", 32'(result_cycles), 0);
        start = 1'b1;
        step();
        step();
        chk("arst_start_ignored", 32'(busy), 0);
        start = 1'b0;
        rst = 1'b1;
        step();
        chk("arst_released_idle", 32'(busy), 0);
        sweep(4'b0011, 0, got);
        chk("arst_sweep_done", 32'(got), 1);
        exp_run("arst_first", 0, 0, 8, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
